cci_host_mem_responder: RTL and testbench
=========================================

// Module: cci_host_mem_responder
// PURPOSE
//  Simulation-side host-memory model answering AFU CCI-P traffic: the FIU/host end of the
//  c0 read-request -> read-response and c1 write-request -> write-ack paths. Holds DEPTH
//  cache lines of backing store and returns responses at fixed latencies with mdata echoed.
//  A bench uses it to run AFU tests (e.g. multiplier/divider) without a real host.
// PARAMETERS
//  DEPTH        64   backing-store size in 512-bit lines (power of 2, >=2)
//  ADDR_W       42   line-address width, matches t_cci_clAddr
//  RD_LATENCY   4    cycles from accepted read request to rd_rsp_valid (>=1)
//  WR_LATENCY   2    cycles from accepted write request to wr_rsp_valid (>=1)
//  AF_THRESH    2    almost-full asserted when in-flight count >= RD_LATENCY+WR_LATENCY-AF_THRESH
// PORTS
//  clk            in   1      clock
//  reset          in   1      asynchronous, active-high reset
//  rd_req_valid   in   1      c0 read request (RDLINE, 1 CL)
//  rd_req_addr    in   ADDR_W line address
//  rd_req_mdata   in   16     request tag
//  rd_rsp_valid   out  1      c0 read response
//  rd_rsp_data    out  512    line data
//  rd_rsp_mdata   out  16     echoed tag
//  wr_req_valid   in   1      c1 write request (WRLINE, 1 CL)
//  wr_req_addr    in   ADDR_W line address
//  wr_req_mdata   in   16     request tag
//  wr_req_data    in   512    line data
//  wr_rsp_valid   out  1      c1 write ack
//  wr_rsp_mdata   out  16     echoed tag
//  almost_full    out  1      c0/c1 almost-full back-pressure hint to AFU
//  init_we        in   1      bench backdoor preload strobe
//  init_addr      in   $clog2(DEPTH) preload index
//  init_data      in   512    preload data
//  err_oob        out  1      sticky: a request addressed >= DEPTH
//  rd_count       out  32     accepted reads, saturating
//  wr_count       out  32     accepted writes, saturating
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0; pipelines flushed; counters 0;
//    err_oob 0; backing store NOT cleared (contents undefined until written/preloaded).
//  - Every valid request is accepted the cycle it is presented; no request is dropped.
//  - Read: memory sampled in acceptance cycle; {data,mdata} shifted through an RD_LATENCY-deep
//    pipeline; rd_rsp_valid high exactly RD_LATENCY cycles later for one cycle. Back-to-back
//    reads give back-to-back responses, in order.
//  - Write: store updated at acceptance edge; {mdata} through WR_LATENCY-deep pipeline;
//    wr_rsp_valid one cycle per write, in order.
//  - Same-cycle read and write to same line: read returns OLD data (read-before-write).
//  - Same-cycle wr_req and init_we to same index: wr_req data wins. Different index: both land.
//  - Index = rd/wr_req_addr[$clog2(DEPTH)-1:0]. If any upper address bit set: err_oob sets
//    (sticky until reset); read returns all-zero data but still responds with mdata; write
//    is acked but store unchanged.
//  - In-flight count = valid stages in both pipelines; almost_full is registered, updated
//    each cycle from the count including that cycle's acceptances.
//  - rd_count/wr_count increment per accepted request, saturate at 32'hFFFF_FFFF.
//  - Reset mid-operation: pending responses discarded, no response ever emitted for them.
// TESTING
//  1. Preload line 3 = 512'h...DEAD_BEEF; read addr 3 mdata 16'h00A5 at cycle T ->
//     rd_rsp_valid at T+4, data ...DEAD_BEEF, mdata 16'h00A5.
//  2. Write addr 5 data {448'b0,32'd42,32'b1} mdata 7 -> wr_rsp_valid at T+2 mdata 7; then
//     read addr 5 -> returns written line; wr_count=1, rd_count=1.
//  3. Same cycle read+write addr 9 (old 0x11, new 0x22) -> read returns 0x11; next read 0x22.
//  4. Reads on 4 consecutive cycles mdata 1..4 -> 4 consecutive responses mdata 1..4;
//     almost_full high while >=4 in flight, low after drain.
//  5. Read addr DEPTH (64) mdata 9 -> err_oob=1, response data 0, mdata 9; write addr 70 ->
//     acked, line 6 unchanged.
//  6. Issue read, assert reset at T+2 -> no rd_rsp_valid afterwards; outputs 0; err_oob 0.

Source files
------------

// File: rtl/cci_host_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : cci_host_mem_responder_if
// Brief   : CCI-P c0 read / c1 write request-response bundle (AFU <-> host).
// Revision: 1.0
// ============================================================================
interface cci_host_mem_responder_if #(
    parameter int ADDR_W = 42
) ();
    logic              rd_req_valid;
    logic [ADDR_W-1:0] rd_req_addr;
    logic [15:0]       rd_req_mdata;
    logic              rd_rsp_valid;
    logic [511:0]      rd_rsp_data;
    logic [15:0]       rd_rsp_mdata;

    logic              wr_req_valid;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [15:0]       wr_req_mdata;
    logic [511:0]      wr_req_data;
    logic              wr_rsp_valid;
    logic [15:0]       wr_rsp_mdata;

    logic              almost_full;

    modport master (
        output rd_req_valid, rd_req_addr, rd_req_mdata,
        output wr_req_valid, wr_req_addr, wr_req_mdata, wr_req_data,
        input  rd_rsp_valid, rd_rsp_data, rd_rsp_mdata,
        input  wr_rsp_valid, wr_rsp_mdata, almost_full
    );

    modport slave (
        input  rd_req_valid, rd_req_addr, rd_req_mdata,
        input  wr_req_valid, wr_req_addr, wr_req_mdata, wr_req_data,
        output rd_rsp_valid, rd_rsp_data, rd_rsp_mdata,
        output wr_rsp_valid, wr_rsp_mdata, almost_full
    );
endinterface
`default_nettype wire

// File: rtl/cci_host_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : cci_host_mem_responder
// Brief   : Host-memory model answering CCI-P reads/writes at fixed latency.
// Revision: 1.0
// ============================================================================
module cci_host_mem_responder #(
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = 42,
    parameter int RD_LATENCY = 4,
    parameter int WR_LATENCY = 2,
    parameter int AF_THRESH  = 2
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    cci_host_mem_responder_if.slave       bus,
    input  wire logic                     init_we_i,
    input  wire logic [$clog2(DEPTH)-1:0] init_addr_i,
    input  wire logic [511:0]             init_data_i,
    output logic                          err_oob_o,
    output logic [31:0]                   rd_count_o,
    output logic [31:0]                   wr_count_o
);
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int FLT_MAX  = RD_LATENCY + WR_LATENCY;
    localparam int CNT_W    = $clog2(FLT_MAX + 1);
    localparam int AF_LEVEL = FLT_MAX - AF_THRESH;

    logic [511:0]          mem_q [DEPTH];

    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      wr_idx;
    logic                  rd_oob;
    logic                  wr_oob;
    logic [511:0]          rd_line;

    logic [RD_LATENCY-1:0] rd_vld_q;
    logic [RD_LATENCY-1:0] rd_vld_d;
    logic [511:0]          rd_data_q  [RD_LATENCY];
    logic [15:0]           rd_mdata_q [RD_LATENCY];
    logic [WR_LATENCY-1:0] wr_vld_q;
    logic [WR_LATENCY-1:0] wr_vld_d;
    logic [15:0]           wr_mdata_q [WR_LATENCY];

    logic [CNT_W-1:0]      inflight_d;
    logic                  almost_full_q;
    logic                  err_oob_q;
    logic [31:0]           rd_count_q;
    logic [31:0]           wr_count_q;

    assign rd_idx  = bus.rd_req_addr[IDX_W-1:0];
    assign wr_idx  = bus.wr_req_addr[IDX_W-1:0];
    assign rd_oob  = |(bus.rd_req_addr >> IDX_W);
    assign wr_oob  = |(bus.wr_req_addr >> IDX_W);
    assign rd_line = rd_oob ? '0 : mem_q[rd_idx];

    // Backing store has no reset; the later write request overrides a same-index preload.
    always_ff @(posedge clk) begin
        if (init_we_i) begin
            mem_q[init_addr_i] <= init_data_i;
        end
        if (bus.wr_req_valid && !wr_oob) begin
            mem_q[wr_idx] <= bus.wr_req_data;
        end
    end

    always_comb begin
        rd_vld_d    = '0;
        wr_vld_d    = '0;
        rd_vld_d[0] = bus.rd_req_valid;
        wr_vld_d[0] = bus.wr_req_valid;
        for (int i = 1; i < RD_LATENCY; i++) begin
            rd_vld_d[i] = rd_vld_q[i-1];
        end
        for (int i = 1; i < WR_LATENCY; i++) begin
            wr_vld_d[i] = wr_vld_q[i-1];
        end
    end

    // Occupancy after this edge, so the registered flag reflects new acceptances.
    always_comb begin
        inflight_d = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight_d = inflight_d + CNT_W'(rd_vld_d[i]);
        end
        for (int i = 0; i < WR_LATENCY; i++) begin
            inflight_d = inflight_d + CNT_W'(wr_vld_d[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld_q <= '0;
            wr_vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                rd_data_q[i]  <= '0;
                rd_mdata_q[i] <= '0;
            end
            for (int i = 0; i < WR_LATENCY; i++) begin
                wr_mdata_q[i] <= '0;
            end
        end else begin
            rd_vld_q      <= rd_vld_d;
            wr_vld_q      <= wr_vld_d;
            rd_data_q[0]  <= rd_line;
            rd_mdata_q[0] <= bus.rd_req_mdata;
            wr_mdata_q[0] <= bus.wr_req_mdata;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_data_q[i]  <= rd_data_q[i-1];
                rd_mdata_q[i] <= rd_mdata_q[i-1];
            end
            for (int i = 1; i < WR_LATENCY; i++) begin
                wr_mdata_q[i] <= wr_mdata_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            almost_full_q <= 1'b0;
            err_oob_q     <= 1'b0;
            rd_count_q    <= '0;
            wr_count_q    <= '0;
        end else begin
            almost_full_q <= (int'(inflight_d) >= AF_LEVEL);
            if ((bus.rd_req_valid && rd_oob) || (bus.wr_req_valid && wr_oob)) begin
                err_oob_q <= 1'b1;
            end
            if (bus.rd_req_valid && (rd_count_q != 32'hFFFF_FFFF)) begin
                rd_count_q <= rd_count_q + 32'd1;
            end
            if (bus.wr_req_valid && (wr_count_q != 32'hFFFF_FFFF)) begin
                wr_count_q <= wr_count_q + 32'd1;
            end
        end
    end

    assign bus.rd_rsp_valid = rd_vld_q[RD_LATENCY-1];
    assign bus.rd_rsp_data  = rd_data_q[RD_LATENCY-1];
    assign bus.rd_rsp_mdata = rd_mdata_q[RD_LATENCY-1];
    assign bus.wr_rsp_valid = wr_vld_q[WR_LATENCY-1];
    assign bus.wr_rsp_mdata = wr_mdata_q[WR_LATENCY-1];
    assign bus.almost_full  = almost_full_q;
    assign err_oob_o        = err_oob_q;
    assign rd_count_o       = rd_count_q;
    assign wr_count_o       = wr_count_q;
endmodule
`default_nettype wire

// File: tb/tb_cci_host_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_cci_host_mem_responder
// Brief   : Directed + random bench against a transaction-level host-memory model.
// Revision: 1.0
// ============================================================================
module tb_cci_host_mem_responder;
    localparam int DEPTH    = 64;
    localparam int ADDR_W   = 42;
    localparam int RDL      = 4;
    localparam int WRL      = 2;
    localparam int AFT      = 2;
    localparam int AF_LEVEL = RDL + WRL - AFT;
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int HMAX     = 4096;

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic              init_we;
    logic [IDX_W-1:0]  init_addr;
    logic [511:0]      init_data;
    logic              err_oob;
    logic [31:0]       rd_count;
    logic [31:0]       wr_count;

    int total = 0;
    int bad   = 0;

    cci_host_mem_responder_if #(.ADDR_W(ADDR_W)) bus ();

    cci_host_mem_responder #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LATENCY(RDL), .WR_LATENCY(WRL), .AF_THRESH(AFT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .init_we_i(init_we), .init_addr_i(init_addr), .init_data_i(init_data),
        .err_oob_o(err_oob), .rd_count_o(rd_count), .wr_count_o(wr_count)
    );

    always #5 clk = ~clk;

    // Reference model: memory image, queues of responses due at a given cycle,
    // and a history of acceptance cycles from which occupancy is derived.
    typedef struct { int due; logic [511:0] data; logic [15:0] mdata; } rd_exp_t;
    typedef struct { int due; logic [15:0] mdata; } wr_exp_t;

    logic [511:0] mem_m [DEPTH];
    rd_exp_t      rdq [$];
    wr_exp_t      wrq [$];
    bit           rd_acc [HMAX];
    bit           wr_acc [HMAX];
    int           cyc = 0;
    logic         err_m;
    logic [31:0]  rd_cnt_m;
    logic [31:0]  wr_cnt_m;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        rdq.delete();
        wrq.delete();
        for (int k = 0; k < HMAX; k++) begin
            rd_acc[k] = 1'b0;
            wr_acc[k] = 1'b0;
        end
        err_m    = 1'b0;
        rd_cnt_m = '0;
        wr_cnt_m = '0;
    endtask

    task automatic idle();
        bus.rd_req_valid = 1'b0; bus.rd_req_addr = '0; bus.rd_req_mdata = '0;
        bus.wr_req_valid = 1'b0; bus.wr_req_addr = '0; bus.wr_req_mdata = '0;
        bus.wr_req_data  = '0;
        init_we = 1'b0; init_addr = '0; init_data = '0;
    endtask

    task automatic set_rd(input logic [ADDR_W-1:0] a, input logic [15:0] m);
        bus.rd_req_valid = 1'b1; bus.rd_req_addr = a; bus.rd_req_mdata = m;
    endtask

    task automatic set_wr(input logic [ADDR_W-1:0] a, input logic [15:0] m, input logic [511:0] d);
        bus.wr_req_valid = 1'b1; bus.wr_req_addr = a; bus.wr_req_mdata = m; bus.wr_req_data = d;
    endtask

    task automatic set_init(input int a, input logic [511:0] d);
        init_we = 1'b1; init_addr = IDX_W'(a); init_data = d;
    endtask

    // One clock: fold this edge's requests into the model, then check the new cycle.
    task automatic tick();
        logic         oob;
        logic         exp_v;
        int           nfl;
        logic [511:0] d;
        @(posedge clk);
        if (bus.rd_req_valid) begin
            oob = (bus.rd_req_addr >> IDX_W) != '0;
            d   = oob ? '0 : mem_m[bus.rd_req_addr[IDX_W-1:0]];
            rdq.push_back('{due: cyc + RDL, data: d, mdata: bus.rd_req_mdata});
            rd_acc[cyc] = 1'b1;
            if (oob) err_m = 1'b1;
            if (rd_cnt_m != 32'hFFFF_FFFF) rd_cnt_m++;
        end
        if (init_we) mem_m[init_addr] = init_data;
        if (bus.wr_req_valid) begin
            oob = (bus.wr_req_addr >> IDX_W) != '0;
            if (!oob) mem_m[bus.wr_req_addr[IDX_W-1:0]] = bus.wr_req_data;
            wrq.push_back('{due: cyc + WRL, mdata: bus.wr_req_mdata});
            wr_acc[cyc] = 1'b1;
            if (oob) err_m = 1'b1;
            if (wr_cnt_m != 32'hFFFF_FFFF) wr_cnt_m++;
        end
        cyc++;
        #1;
        exp_v = (rdq.size() > 0) && (rdq[0].due == cyc);
        chk("rd_rsp_valid", 512'(bus.rd_rsp_valid), 512'(exp_v));
        if (exp_v) begin
            chk("rd_rsp_data", bus.rd_rsp_data, rdq[0].data);
            chk("rd_rsp_mdata", 512'(bus.rd_rsp_mdata), 512'(rdq[0].mdata));
            void'(rdq.pop_front());
        end
        exp_v = (wrq.size() > 0) && (wrq[0].due == cyc);
        chk("wr_rsp_valid", 512'(bus.wr_rsp_valid), 512'(exp_v));
        if (exp_v) begin
            chk("wr_rsp_mdata", 512'(bus.wr_rsp_mdata), 512'(wrq[0].mdata));
            void'(wrq.pop_front());
        end
        nfl = 0;
        for (int k = 1; k <= RDL; k++) if (cyc - k >= 0 && rd_acc[cyc-k]) nfl++;
        for (int k = 1; k <= WRL; k++) if (cyc - k >= 0 && wr_acc[cyc-k]) nfl++;
        chk("almost_full", 512'(bus.almost_full), 512'(nfl >= AF_LEVEL));
        chk("err_oob", 512'(err_oob), 512'(err_m));
        chk("rd_count", 512'(rd_count), 512'(rd_cnt_m));
        chk("wr_count", 512'(wr_count), 512'(wr_cnt_m));
    endtask

    // Asynchronous assertion mid-cycle; every output must drop without a clock edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_clear();
        chk("rst_rd_rsp_valid", 512'(bus.rd_rsp_valid), '0);
        chk("rst_rd_rsp_data", bus.rd_rsp_data, '0);
        chk("rst_rd_rsp_mdata", 512'(bus.rd_rsp_mdata), '0);
        chk("rst_wr_rsp_valid", 512'(bus.wr_rsp_valid), '0);
        chk("rst_wr_rsp_mdata", 512'(bus.wr_rsp_mdata), '0);
        chk("rst_almost_full", 512'(bus.almost_full), '0);
        chk("rst_err_oob", 512'(err_oob), '0);
        chk("rst_rd_count", 512'(rd_count), '0);
        chk("rst_wr_count", 512'(wr_count), '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [511:0] rnd_line();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        idle();
        do_reset();

        for (int i = 0; i < DEPTH; i++) begin
            set_init(i, rnd_line());
            tick();
        end
        idle();

        // Preloaded line read back after exactly RDL cycles.
        set_init(3, {480'b0, 32'hDEAD_BEEF});
        tick();
        idle();
        set_rd(ADDR_W'(3), 16'h00A5);
        tick();
        idle();
        repeat (5) tick();

        // Write, ack, then read back the written line.
        set_wr(ADDR_W'(5), 16'd7, {448'b0, 32'd42, 32'd1});
        tick();
        idle();
        tick();
        set_rd(ADDR_W'(5), 16'h0055);
        tick();
        idle();
        repeat (5) tick();

        // Same-cycle read and write to one line returns the old contents.
        set_init(9, 512'h11);
        tick();
        idle();
        set_rd(ADDR_W'(9), 16'h0031);
        set_wr(ADDR_W'(9), 16'h0032, 512'h22);
        tick();
        idle();
        set_rd(ADDR_W'(9), 16'h0033);
        tick();
        idle();
        repeat (5) tick();

        // Four back-to-back reads drive the occupancy to the almost-full level.
        for (int m = 1; m <= 4; m++) begin
            set_rd(ADDR_W'(m), 16'(m));
            tick();
        end
        idle();
        repeat (6) tick();

        // Preload vs. write request: same index, then different indices.
        set_init(12, 512'hAAAA);
        set_wr(ADDR_W'(12), 16'h0040, 512'hBBBB);
        tick();
        set_init(13, 512'hCCCC);
        set_wr(ADDR_W'(14), 16'h0041, 512'hDDDD);
        tick();
        idle();
        for (int a = 12; a <= 14; a++) begin
            set_rd(ADDR_W'(a), 16'(16'h0050 + a));
            tick();
        end
        idle();
        repeat (5) tick();

        // Out-of-range read and write.
        set_rd(ADDR_W'(DEPTH), 16'd9);
        tick();
        idle();
        set_wr(ADDR_W'(70), 16'h0012, rnd_line());
        tick();
        idle();
        set_rd(ADDR_W'(6), 16'h0013);
        tick();
        idle();
        repeat (5) tick();

        // Reset with a read in flight: the response must never appear.
        set_rd(ADDR_W'(1), 16'h0077);
        tick();
        idle();
        tick();
        do_reset();
        repeat (8) tick();

        // Randomised traffic with frequent collisions and occasional bad addresses.
        for (int n = 0; n < 400; n++) begin
            logic [ADDR_W-1:0] a;
            idle();
            if ($urandom_range(0, 1) == 1) begin
                a = ADDR_W'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1));
                if ($urandom_range(0, 31) == 0) a = a | (ADDR_W'(1) << $urandom_range(IDX_W, ADDR_W - 1));
                set_rd(a, 16'($urandom));
            end
            if ($urandom_range(0, 1) == 1) begin
                a = ADDR_W'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1));
                if ($urandom_range(0, 31) == 0) a = a | (ADDR_W'(1) << $urandom_range(IDX_W, ADDR_W - 1));
                set_wr(a, 16'($urandom), rnd_line());
            end
            if ($urandom_range(0, 7) == 0) set_init($urandom_range(0, 3), rnd_line());
            tick();
        end
        idle();
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
